lsu_align_split: RTL and testbench

//  Parametrised load/store data aligner for the memory stage; sits between the pipeline and the data bus.

---
 rtl/lsu_align_split.sv | 159 +++++++++++++++
 tb/tb_lsu_align_split.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_align_split.sv
// rtl/lsu_align_split.sv - load/store aligner: byte strobes, lane shifting, boundary split, load extension
// One request in flight; boundary-crossing accesses become two bus beats or an rsp_err response.
module lsu_align_split #(
  parameter int DATA_W         = 32,
  parameter bit ALLOW_MISALIGN = 1'b1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [31:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                bus_valid,
  input  logic                bus_ready,
  output logic                bus_write,
  output logic [31:0]         bus_addr,
  output logic [DATA_W/8-1:0] bus_strobe,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFS_W = $clog2(BYTES);

  typedef enum logic [2:0] {IDLE, BUS0, WAIT0, BUS1, WAIT1, RESP} state_t;
  state_t state, state_nx;

  logic              r_write, r_signed, r_cross, r_err;
  logic [1:0]        r_size;
  logic [31:0]       r_addr;
  logic [DATA_W-1:0] r_wdata, beat0, beat1;

  logic              accept;
  logic [OFS_W-1:0]  req_ofs, ofs;
  logic [4:0]        req_span;
  logic              req_cross, req_err;

  assign accept    = req_valid && req_ready;
  assign req_ofs   = req_addr[OFS_W-1:0];
  assign req_span  = 5'(req_ofs) + (5'd1 << req_size);
  assign req_cross = req_span > 5'(BYTES);
  assign req_err   = ((DATA_W == 32) && (req_size == 2'd3)) || (req_cross && !ALLOW_MISALIGN);

  // Datapath views of the latched request
  logic [OFS_W+2:0]    sh_amt;
  logic [31:0]         base;
  logic [2*DATA_W-1:0] wsh, rsh;
  logic [2*BYTES-1:0]  nmask, smask;
  logic [DATA_W-1:0]   ext;
  logic                sb;
  int                  nb;

  assign ofs    = r_addr[OFS_W-1:0];
  assign sh_amt = {ofs, 3'b000};
  assign base   = {r_addr[31:OFS_W], {OFS_W{1'b0}}};
  assign wsh    = {{DATA_W{1'b0}}, r_wdata} << sh_amt;
  assign rsh    = {beat1, beat0} >> sh_amt;
  assign smask  = nmask << ofs;

  always_comb begin
    nmask = '0;
    sb    = 1'b0;
    ext   = '0;
    nb    = 8 << r_size;
    case (r_size)
      2'd0: begin nmask = (2*BYTES)'(8'h01); sb = rsh[7];  end
      2'd1: begin nmask = (2*BYTES)'(8'h03); sb = rsh[15]; end
      2'd2: begin nmask = (2*BYTES)'(8'h0F); sb = rsh[31]; end
      default: begin nmask = (2*BYTES)'(8'hFF); sb = rsh[63]; end
    endcase
    for (int i = 0; i < DATA_W; i++) ext[i] = (i < nb) ? rsh[i] : (r_signed & sb);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    bus_valid  = 1'b0;
    bus_write  = 1'b0;
    bus_addr   = '0;
    bus_strobe = '0;
    bus_wdata  = '0;
    rsp_valid  = 1'b0;
    rsp_err    = 1'b0;
    rsp_rdata  = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) state_nx = req_err ? RESP : BUS0;
      end
      BUS0: begin
        bus_valid  = 1'b1;
        bus_write  = r_write;
        bus_addr   = base;
        bus_strobe = r_write ? smask[BYTES-1:0] : '1;
        bus_wdata  = wsh[DATA_W-1:0];
        if (bus_ready) state_nx = WAIT0;
      end
      WAIT0: if (bus_rvalid) state_nx = r_cross ? BUS1 : RESP;
      BUS1: begin
        bus_valid  = 1'b1;
        bus_write  = r_write;
        bus_addr   = base + 32'(BYTES);
        bus_strobe = r_write ? smask[2*BYTES-1:BYTES] : '1;
        bus_wdata  = wsh[2*DATA_W-1:DATA_W];
        if (bus_ready) state_nx = WAIT1;
      end
      WAIT1: if (bus_rvalid) state_nx = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = r_err;
        rsp_rdata = (r_write || r_err) ? '0 : ext;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_write  <= 1'b0;
      r_signed <= 1'b0;
      r_cross  <= 1'b0;
      r_err    <= 1'b0;
      r_size   <= 2'd0;
      r_addr   <= '0;
      r_wdata  <= '0;
      beat0    <= '0;
      beat1    <= '0;
    end else begin
      if (accept) begin
        r_write  <= req_write;
        r_signed <= req_signed;
        r_cross  <= req_cross;
        r_err    <= req_err;
        r_size   <= req_size;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        beat0    <= '0;
        beat1    <= '0;
      end
      if (state == WAIT0 && bus_rvalid) beat0 <= bus_rdata;
      if (state == WAIT1 && bus_rvalid) beat1 <= bus_rdata;
    end
  end

endmodule

// File: tb/tb_lsu_align_split.sv
// tb/tb_lsu_align_split.sv - scoreboard bench for lsu_align_split (DATA_W=32)
// Expected beats/responses are queued at issue time; negedge monitors pop and compare.
module tb_lsu_align_split;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        bus_valid, bus_ready, bus_write;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_strobe;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata  = 32'h0;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        m_req_valid, m_req_ready, m_req_write, m_req_signed;
  logic [1:0]  m_req_size;
  logic [31:0] m_req_addr, m_req_wdata;
  logic        m_bus_valid, m_bus_ready, m_bus_write, m_bus_rvalid;
  logic [31:0] m_bus_addr, m_bus_wdata, m_bus_rdata;
  logic [3:0]  m_bus_strobe;
  logic        m_rsp_valid, m_rsp_ready, m_rsp_err;
  logic [31:0] m_rsp_rdata;

  lsu_align_split #(.DATA_W(32), .ALLOW_MISALIGN(1'b1)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_strobe(bus_strobe), .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  lsu_align_split #(.DATA_W(32), .ALLOW_MISALIGN(1'b0)) dut_strict (
    .clk(clk), .resetn(resetn),
    .req_valid(m_req_valid), .req_ready(m_req_ready), .req_write(m_req_write), .req_size(m_req_size),
    .req_signed(m_req_signed), .req_addr(m_req_addr), .req_wdata(m_req_wdata),
    .bus_valid(m_bus_valid), .bus_ready(m_bus_ready), .bus_write(m_bus_write), .bus_addr(m_bus_addr),
    .bus_strobe(m_bus_strobe), .bus_wdata(m_bus_wdata), .bus_rvalid(m_bus_rvalid), .bus_rdata(m_bus_rdata),
    .rsp_valid(m_rsp_valid), .rsp_ready(m_rsp_ready), .rsp_rdata(m_rsp_rdata), .rsp_err(m_rsp_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] wdata;
    logic        write;
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  beat_t       exp_beats[$];
  rsp_t        exp_rsps[$];
  logic [31:0] rd_q[$];
  int          checks = 0;
  int          failures = 0;
  int          nrsp = 0;
  logic        rv_pend = 1'b0;
  beat_t       b;
  rsp_t        r;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  function automatic void push_beat(input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd, input logic w);
    beat_t nbt;
    nbt.addr = a; nbt.strobe = s; nbt.wdata = wd; nbt.write = w;
    exp_beats.push_back(nbt);
  endfunction

  function automatic void push_rsp(input logic [31:0] rd, input logic e);
    rsp_t nr;
    nr.rdata = rd; nr.err = e;
    exp_rsps.push_back(nr);
  endfunction

  // Bus model: checks each accepted beat, completes it on the following cycle
  always @(negedge clk) begin
    bus_rvalid = 1'b0;
    bus_rdata  = 32'h0;
    if (!resetn) begin
      rv_pend = 1'b0;
    end else begin
      if (rv_pend) begin
        bus_rvalid = 1'b1;
        if (rd_q.size() != 0) bus_rdata = rd_q.pop_front();
        rv_pend = 1'b0;
      end
      if (bus_valid && bus_ready) begin
        if (exp_beats.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual_addr=0x%0h required=none", bus_addr);
        end else begin
          b = exp_beats.pop_front();
          check("beat_addr",   64'(bus_addr),   64'(b.addr));
          check("beat_strobe", 64'(bus_strobe), 64'(b.strobe));
          check("beat_wdata",  64'(bus_wdata),  64'(b.wdata));
          check("beat_write",  64'(bus_write),  64'(b.write));
        end
        rv_pend = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (resetn && rsp_valid && rsp_ready) begin
      nrsp++;
      check("rsp_req_ready_low", 64'(req_ready), 64'(0));
      if (exp_rsps.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual_rdata=0x%0h required=none", rsp_rdata);
      end else begin
        r = exp_rsps.pop_front();
        check("rsp_rdata", 64'(rsp_rdata), 64'(r.rdata));
        check("rsp_err",   64'(rsp_err),   64'(r.err));
      end
    end
  end

  task automatic issue(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [31:0] wd);
    int k = 0;
    while (!req_ready && k < 100) begin @(posedge clk); #1; k++; end
    check("req_ready_before_issue", 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
  endtask

  task automatic wait_rsp(input int target);
    int k = 0;
    while (nrsp < target && k < 200) begin @(posedge clk); #1; k++; end
    check("rsp_count", 64'(nrsp), 64'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n = 0;
    int lat, k, bv, got;
    logic m_err;
    logic [31:0] m_rd;

    resetn = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    bus_ready = 1'b1; rsp_ready = 1'b1;
    m_req_valid = 1'b0; m_req_write = 1'b0; m_req_size = 2'd0; m_req_signed = 1'b0;
    m_req_addr = 32'h0; m_req_wdata = 32'h0; m_bus_ready = 1'b1; m_bus_rvalid = 1'b0;
    m_bus_rdata = 32'h0; m_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready",  64'(req_ready),  64'(1));
    check("rst_bus_valid",  64'(bus_valid),  64'(0));
    check("rst_rsp_valid",  64'(rsp_valid),  64'(0));
    check("rst_rsp_err",    64'(rsp_err),    64'(0));
    check("rst_bus_addr",   64'(bus_addr),   64'(0));
    check("rst_bus_strobe", 64'(bus_strobe), 64'(0));
    check("rst_bus_wdata",  64'(bus_wdata),  64'(0));
    check("rst_rsp_rdata",  64'(rsp_rdata),  64'(0));
    resetn = 1'b1;
    @(posedge clk); #1;

    // LB signed at 0x103
    push_beat(32'h100, 4'hF, 32'h0, 1'b0); rd_q.push_back(32'h8000_0000);
    push_rsp(32'hFFFF_FF80, 1'b0);
    issue(1'b0, 2'd0, 1'b1, 32'h103, 32'h0); n++; wait_rsp(n);

    // LHU at 0x103 crosses into 0x104
    push_beat(32'h100, 4'hF, 32'h0, 1'b0); rd_q.push_back(32'hAB00_0000);
    push_beat(32'h104, 4'hF, 32'h0, 1'b0); rd_q.push_back(32'h0000_00CD);
    push_rsp(32'h0000_CDAB, 1'b0);
    issue(1'b0, 2'd1, 1'b0, 32'h103, 32'h0); n++; wait_rsp(n);

    // SW at 0x102 split in two beats
    push_beat(32'h100, 4'b1100, 32'h3344_0000, 1'b1); rd_q.push_back(32'h0);
    push_beat(32'h104, 4'b0011, 32'h0000_1122, 1'b1); rd_q.push_back(32'h0);
    push_rsp(32'h0, 1'b0);
    issue(1'b1, 2'd2, 1'b0, 32'h102, 32'h1122_3344); n++; wait_rsp(n);

    // LW at 0xFFFF_FFFE wraps to address 0
    push_beat(32'hFFFF_FFFC, 4'hF, 32'h0, 1'b0); rd_q.push_back(32'h5678_0000);
    push_beat(32'h0000_0000, 4'hF, 32'h0, 1'b0); rd_q.push_back(32'h0000_1234);
    push_rsp(32'h1234_5678, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h0); n++; wait_rsp(n);

    // LH signed aligned half at 0x202
    push_beat(32'h200, 4'hF, 32'h0, 1'b0); rd_q.push_back(32'h8001_0000);
    push_rsp(32'hFFFF_8001, 1'b0);
    issue(1'b0, 2'd1, 1'b1, 32'h202, 32'h0); n++; wait_rsp(n);

    // SB at 0x301
    push_beat(32'h300, 4'b0010, 32'h0000_AA00, 1'b1); rd_q.push_back(32'h0);
    push_rsp(32'h0, 1'b0);
    issue(1'b1, 2'd0, 1'b0, 32'h301, 32'h0000_00AA); n++; wait_rsp(n);

    // dword on a 32-bit bus is illegal: no beat, error response
    push_rsp(32'h0, 1'b1);
    issue(1'b0, 2'd3, 1'b0, 32'h0, 32'h0); n++; wait_rsp(n);

    // LBU at 0x3
    push_beat(32'h0, 4'hF, 32'h0, 1'b0); rd_q.push_back(32'h8000_0000);
    push_rsp(32'h0000_0080, 1'b0);
    issue(1'b0, 2'd0, 1'b0, 32'h3, 32'h0); n++; wait_rsp(n);

    // Minimum latency: rsp_valid three cycles after the accept cycle
    push_beat(32'h300, 4'hF, 32'h0, 1'b0); rd_q.push_back(32'hCAFE_F00D);
    push_rsp(32'hCAFE_F00D, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h300, 32'h0); n++;
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("min_latency", 64'(lat), 64'(2));
    wait_rsp(n);

    // Back-pressure on bus and response
    bus_ready = 1'b0; rsp_ready = 1'b0;
    push_beat(32'h104, 4'hF, 32'h0, 1'b0); rd_q.push_back(32'h7FFF_0000);
    push_rsp(32'h0000_7FFF, 1'b0);
    issue(1'b0, 2'd1, 1'b1, 32'h106, 32'h0); n++;
    repeat (5) begin
      check("stall_bus_valid",  64'(bus_valid),  64'(1));
      check("stall_bus_addr",   64'(bus_addr),   64'(32'h104));
      check("stall_bus_strobe", 64'(bus_strobe), 64'(4'hF));
      @(posedge clk); #1;
    end
    bus_ready = 1'b1;
    k = 0;
    while (!rsp_valid && k < 20) begin @(posedge clk); #1; k++; end
    repeat (3) begin
      check("hold_rsp_valid", 64'(rsp_valid), 64'(1));
      check("hold_rsp_rdata", 64'(rsp_rdata), 64'(32'h0000_7FFF));
      check("hold_rsp_count", 64'(nrsp),      64'(n - 1));
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    wait_rsp(n);
    repeat (4) begin @(posedge clk); #1; end
    check("single_rsp", 64'(nrsp), 64'(n));

    // Reset while waiting for the first beat's completion
    push_beat(32'h400, 4'hF, 32'h0, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    check("midrst_req_ready", 64'(req_ready), 64'(1));
    check("midrst_bus_valid", 64'(bus_valid), 64'(0));
    check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("midrst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    resetn = 1'b1;
    @(posedge clk); #1;
    push_beat(32'h500, 4'hF, 32'h0, 1'b0); rd_q.push_back(32'h0102_0304);
    push_rsp(32'h0102_0304, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h500, 32'h0); n++; wait_rsp(n);

    // Strict instance rejects a boundary-crossing word without touching the bus
    check("strict_req_ready", 64'(m_req_ready), 64'(1));
    m_req_valid = 1'b1; m_req_size = 2'd2; m_req_addr = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    m_req_valid = 1'b0;
    bv = 0; got = 0; m_err = 1'b0; m_rd = 32'hDEAD_BEEF;
    for (int i = 0; i < 8; i++) begin
      if (m_bus_valid) bv++;
      if (m_rsp_valid && got == 0) begin got = 1; m_err = m_rsp_err; m_rd = m_rsp_rdata; end
      @(posedge clk); #1;
    end
    check("strict_no_bus",  64'(bv),    64'(0));
    check("strict_got_rsp", 64'(got),   64'(1));
    check("strict_err",     64'(m_err), 64'(1));
    check("strict_rdata",   64'(m_rd),  64'(0));

    check("beats_left", 64'(exp_beats.size()), 64'(0));
    check("rsps_left",  64'(exp_rsps.size()),  64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
